// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state codes and default width.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fa_slice.sv
// Combinational 1-bit full adder; the single arithmetic slice reused every cycle by serial_add_ctrl.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c;
    assign c_out = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice walked LSB-first over WIDTH-bit operands.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b with c_out = no-borrow).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] b_load;
    logic [WIDTH-1:0] sum_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             carry_load;
    logic             s_bit;
    logic             co_bit;
    logic             load;
    logic             last_bit;

    fa_slice u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry),
        .sum   (s_bit),
        .c_out (co_bit)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign load      = in_valid && in_ready;
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

    // Subtraction is a + ~b + 1, so the no-borrow flag falls out as the carry.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : c_in;
`else
        b_load     = b;
        carry_load = c_in;
`endif
    end

    always_comb begin
        sum_next            = sum >> 1;
        sum_next[WIDTH-1]   = s_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            sum   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            c_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        a_sr  <= a;
                        b_sr  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum   <= sum_next;
                    carry <= co_bit;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        c_out <= co_bit;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vectors, back-pressure, mid-run reset, random ops.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    int tests_run;
    int tests_failed;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic, {c_out, sum}.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci, input logic sb);
        logic [W:0] r;
        if (sb) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        end
        return r;
    endfunction

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tc);
        a        = ta;
        b        = tb_op;
        c_in     = tc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        c_in     = 1'($urandom);
    endtask

    // out_ready is toggled randomly while not in DONE; it must have no effect there.
    task automatic wait_done(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < int'(W) + 20) begin
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        #2;
        tests_run++;
        if ({in_ready, out_valid, busy, c_out, sum} !== {4'b1000, {W{1'b0}}}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b co=%b sum=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, c_out, sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W:0]   ve [3] = '{9'h096, 9'h100, 9'h1FF};
        int lat;
        op_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i], vc[i]);
            tests_run++;
            if ({in_ready, busy} !== 2'b01) begin
                tests_failed++;
                $display("FAIL dir%0d_after_load: got rdy=%b busy=%b, want 0 1", i, in_ready, busy);
            end
            wait_done(lat);
            tests_run++;
            if (lat !== int'(W) + 1) begin
                tests_failed++;
                $display("FAIL dir%0d_latency: got %0d cycles, want %0d", i, lat, W + 1);
            end
            tests_run++;
            if ({c_out, sum} !== ve[i]) begin
                tests_failed++;
                $display("FAIL dir%0d_result: got co=%b sum=%h, want %h", i, c_out, sum, ve[i]);
            end
            release_op();
            tests_run++;
            if ({in_ready, busy} !== 2'b10) begin
                tests_failed++;
                $display("FAIL dir%0d_back_to_idle: got rdy=%b busy=%b, want 1 0", i, in_ready, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] exp;
        int lat;
        op_sub = 1'b0;
        exp = ref_result(8'hC3, 8'h7E, 1'b1, 1'b0);
        start_op(8'hC3, 8'h7E, 1'b1);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            a = 8'h11; b = 8'h22; c_in = 1'b0;
            @(posedge clk);
            #1;
            tests_run++;
            if ({out_valid, in_ready, c_out, sum} !== {2'b10, exp}) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: got vld=%b rdy=%b co=%b sum=%h, want 1 0 %h",
                         i, out_valid, in_ready, c_out, sum, exp);
            end
        end
        in_valid = 1'b0;
        release_op();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b busy=%b, want 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        op_sub = 1'b0;
        start_op(8'hA5, 8'h5A, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, out_valid, busy, c_out, sum} !== {4'b1000, {W{1'b0}}}) begin
            tests_failed++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b co=%b sum=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, c_out, sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(lat);
        tests_run++;
        if ({lat, c_out, sum} !== {int'(W) + 1, 9'h002}) begin
            tests_failed++;
            $display("FAIL post_reset_op: got lat=%0d co=%b sum=%h, want lat=%0d 002",
                     lat, c_out, sum, W + 1);
        end
        release_op();
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        logic [W-1:0] va [2] = '{8'h10, 8'h00};
        logic [W-1:0] vb [2] = '{8'h01, 8'h01};
        logic [W:0]   ve [2] = '{9'h10F, 9'h0FF};
        int lat;
        op_sub = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], 1'($urandom));
            wait_done(lat);
            tests_run++;
            if ({c_out, sum} !== ve[i]) begin
                tests_failed++;
                $display("FAIL sub%0d_result: got co=%b sum=%h, want %h", i, c_out, sum, ve[i]);
            end
            release_op();
        end
        op_sub = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   exp;
        int lat;
        int hold;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            op_sub = 1'($urandom);
`else
            op_sub = 1'b0;
`endif
            exp = ref_result(ra, rb, rc, op_sub);
            start_op(ra, rb, rc);
            wait_done(lat);
            tests_run++;
            if ({lat, c_out, sum} !== {int'(W) + 1, exp}) begin
                tests_failed++;
                $display("FAIL rand%0d: a=%h b=%h ci=%b sub=%b got lat=%0d co=%b sum=%h, want lat=%0d %h",
                         i, ra, rb, rc, op_sub, lat, c_out, sum, W + 1, exp);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            release_op();
        end
        op_sub = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
